// File: rtl/m6809_busgrant_ctrl_if.sv
// m6809_busgrant_ctrl_if
//   Bus-handover signal bundle between the 6809 card glue and the grant
//   controller. hsclk/rst are kept as plain ports on the controller.
//
//   CPU / requester side (driven into the controller):
//     ba, bs        - 6809 BA / BS, asynchronous to hsclk
//     ext_busrq_b   - expansion bus request, active-low, asynchronous
//     dma_req       - local DMA request, active-high, hsclk-synchronous
//   Controller side (registered outputs):
//     halt_b        - to 6809 HALT_B
//     ext_busack_b  - expansion bus acknowledge, active-low
//     dma_gnt       - local DMA grant
//     bus_busy      - bus held by a non-CPU master (LED1)
//     wdog_err      - one-cycle halt-acknowledge timeout pulse
//
//   master: the side that drives requests and BA/BS (board / bench)
//   slave : the grant controller
interface m6809_busgrant_ctrl_if;
  logic ba;
  logic bs;
  logic ext_busrq_b;
  logic dma_req;
  logic halt_b;
  logic ext_busack_b;
  logic dma_gnt;
  logic bus_busy;
  logic wdog_err;

  modport master (
    output ba, bs, ext_busrq_b, dma_req,
    input  halt_b, ext_busack_b, dma_gnt, bus_busy, wdog_err
  );

  modport slave (
    input  ba, bs, ext_busrq_b, dma_req,
    output halt_b, ext_busack_b, dma_gnt, bus_busy, wdog_err
  );
endinterface

// File: rtl/m6809_busgrant_ctrl.sv
// m6809_busgrant_ctrl
//   Hands the 6809 system bus to one of two masters (expansion connector
//   or card-local DMA). The CPU is halted, the controller waits for
//   BA && BS, then issues an exclusive grant. After the master lets go and
//   the CPU drops BA, a gap of GAP_CYCLES keeps the bus with the CPU before
//   any new halt, so the CPU cannot be starved. Ties alternate between the
//   masters (first tie after reset goes to the expansion side).
//
//   Ports:
//     hsclk  - sole clock
//     rst    - synchronous, active-high reset
//     bus    - m6809_busgrant_ctrl_if.slave (ba, bs, ext_busrq_b, dma_req in;
//              halt_b, ext_busack_b, dma_gnt, bus_busy, wdog_err out)
//
//   Parameters:
//     SYNC_STAGES - synchroniser depth for ba/bs/ext_busrq_b (2..3)
//     GAP_CYCLES  - CPU-owned cycles after BA drops (1..255)
//     WDOG_CYCLES - WAIT_BA cycles before timeout (WDOG_EN builds only)
//
//   Build option:
//     WDOG_EN - when defined, a halt-acknowledge watchdog aborts WAIT_BA
//               after WDOG_CYCLES, pulses wdog_err and masks the stalled
//               requester until it drops its request. Undefined: WAIT_BA
//               waits forever and wdog_err is tied low.
module m6809_busgrant_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int GAP_CYCLES  = 16,
  parameter int WDOG_CYCLES = 1024
) (
  input logic                  hsclk,
  input logic                  rst,
  m6809_busgrant_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HALT_REQ = 3'd1,
    WAIT_BA  = 3'd2,
    GRANT    = 3'd3,
    RELEASE  = 3'd4,
    GAP      = 3'd5
  } state_t;

  typedef enum logic {
    OWN_EXT = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  // asynchronous pins, synchronised together
  typedef struct packed {
    logic ba;
    logic bs;
    logic busrq_b;
  } pin_t;

  // ---------------------------------------------------------------------
  // Synchronisers. Not reset: rst is held for several cycles at power-up,
  // which flushes the chain before the FSM leaves reset.
  // ---------------------------------------------------------------------
  pin_t                   pin_raw;
  pin_t [SYNC_STAGES-1:0] sync_pipe;
  logic                   ba_s;
  logic                   bs_s;
  logic                   ext_req_s;

  assign pin_raw = '{ba: bus.ba, bs: bus.bs, busrq_b: bus.ext_busrq_b};

  always_ff @(posedge hsclk) begin
    sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], pin_raw};
  end

  assign ba_s      = sync_pipe[SYNC_STAGES-1].ba;
  assign bs_s      = sync_pipe[SYNC_STAGES-1].bs;
  assign ext_req_s = !sync_pipe[SYNC_STAGES-1].busrq_b;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t     state_q, state_d;
  owner_t     owner_q, owner_d;
  owner_t     last_q, last_d;
  logic [7:0] gap_q, gap_d;

  logic halt_b_q;
  logic ext_busack_b_q;
  logic dma_gnt_q;
  logic bus_busy_q;

  logic halt_ack;
  logic own_req;
  logic ext_eff;
  logic dma_eff;

  assign halt_ack = ba_s && bs_s;
  // The owner's own request is never masked while it holds the FSM.
  assign own_req  = (owner_q == OWN_DMA) ? bus.dma_req : ext_req_s;

`ifdef WDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);

  logic [WDW-1:0] wd_q;
  logic [WDW-1:0] wd_inc;
  logic           wd_hit;
  logic           timeout;
  logic           mask_ext_q;
  logic           mask_dma_q;
  logic           wdog_err_q;

  assign wd_inc  = (wd_q == '1) ? wd_q : wd_q + 1'b1;
  assign wd_hit  = (wd_inc == WDW'(WDOG_CYCLES));
  // A timed-out requester is ignored until it releases its request.
  assign ext_eff = ext_req_s   && !mask_ext_q;
  assign dma_eff = bus.dma_req && !mask_dma_q;
`else
  assign ext_eff = ext_req_s;
  assign dma_eff = bus.dma_req;
`endif

  // ---------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gap_d   = gap_q;
`ifdef WDOG_EN
    timeout = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (ext_eff || dma_eff) begin
          state_d = HALT_REQ;
          if (ext_eff && dma_eff)
            owner_d = (last_q == OWN_DMA) ? OWN_EXT : OWN_DMA;
          else
            owner_d = dma_eff ? OWN_DMA : OWN_EXT;
        end
      end
      HALT_REQ: state_d = WAIT_BA;
      WAIT_BA: begin
        // A withdrawn request wins over a simultaneous acknowledge so a
        // grant is never handed to a master that has already gone away.
        if (!own_req) begin
          state_d = RELEASE;
        end else if (halt_ack) begin
          state_d = GRANT;
          last_d  = owner_q;
        end
`ifdef WDOG_EN
        else if (wd_hit) begin
          state_d = RELEASE;
          timeout = 1'b1;
        end
`endif
      end
      GRANT: begin
        if (!own_req) state_d = RELEASE;
      end
      RELEASE: begin
        if (!ba_s) begin
          state_d = GAP;
          gap_d   = 8'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (gap_q == 8'd0) state_d = IDLE;
        else               gap_d   = gap_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state. HALT_REQ is the cycle in
  // which the halt is being registered, so halt_b goes low on the edge
  // that enters WAIT_BA (two edges after a request is seen in IDLE).
  logic grant_d;
  assign grant_d = (state_d == GRANT);

  always_ff @(posedge hsclk) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= OWN_DMA;
      last_q         <= OWN_DMA;
      gap_q          <= 8'd0;
      halt_b_q       <= 1'b1;
      ext_busack_b_q <= 1'b1;
      dma_gnt_q      <= 1'b0;
      bus_busy_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_q         <= last_d;
      gap_q          <= gap_d;
      halt_b_q       <= !(state_d == WAIT_BA || state_d == GRANT);
      ext_busack_b_q <= !(grant_d && owner_d == OWN_EXT);
      dma_gnt_q      <= grant_d && owner_d == OWN_DMA;
      bus_busy_q     <= grant_d;
    end
  end

`ifdef WDOG_EN
  always_ff @(posedge hsclk) begin
    if (rst) begin
      wd_q       <= '0;
      mask_ext_q <= 1'b0;
      mask_dma_q <= 1'b0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_err_q <= timeout;
      if (state_d == HALT_REQ)      wd_q <= '0;
      else if (state_q == WAIT_BA)  wd_q <= wd_inc;
      mask_ext_q <= (mask_ext_q && ext_req_s)   || (timeout && owner_q == OWN_EXT);
      mask_dma_q <= (mask_dma_q && bus.dma_req) || (timeout && owner_q == OWN_DMA);
    end
  end

  assign bus.wdog_err = wdog_err_q;
`else
  assign bus.wdog_err = 1'b0;
`endif

  assign bus.halt_b       = halt_b_q;
  assign bus.ext_busack_b = ext_busack_b_q;
  assign bus.dma_gnt      = dma_gnt_q;
  assign bus.bus_busy     = bus_busy_q;

endmodule
